// File: rtl/q_frag_pkg.sv
// Purpose: shared types and constants for the q_frag register cluster.
// Latency: n/a (types only).
// Backpressure: n/a.
package q_frag_pkg;

    // Configuration FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        APPLY = 2'd2,
        RUN   = 2'd3
    } state_t;

    // Each slice owns one INIT bit and one ZINV bit in the config chain.
    localparam int CFG_BITS_PER_CELL = 2;

endpackage

// File: rtl/q_frag_slice.sv
// Purpose: one register bit behind an F-mux fragment: d-mux, set/enable priority, init load, output inversion.
// Latency: d to qz is one clock edge while run is high.
// Backpressure: none; the slice captures whenever run and qen/qst allow.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   run               high while the cluster is in RUN; gates qst/qen
//   load_init         one-cycle strobe that loads init_bit into the flop
//   init_bit          configured power-up value
//   qds, fz, qdi      data select and the two data candidates
//   qen, qst          slice enable and shared synchronous set
//   zinv              configured output inversion
//   qz                registered output after inversion
module q_frag_slice (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic load_init,
    input  logic init_bit,
    input  logic qds,
    input  logic fz,
    input  logic qdi,
    input  logic qen,
    input  logic qst,
    input  logic zinv,
    output logic qz
);

    logic q;
    logic d;

    assign d = qds ? qdi : fz;

    // Set beats enable; outside RUN the flop only changes on the init load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (load_init) begin
            q <= init_bit;
        end else if (run) begin
            if (qst) begin
                q <= 1'b1;
            end else if (qen) begin
                q <= d;
            end
        end
    end

    assign qz = q ^ zinv;

endmodule

// File: rtl/q_frag_cluster.sv
// Purpose: NUM_CELLS register slices with INIT/ZINV loaded over a daisy-chainable serial config chain.
// Latency: FZ/QDI to QZ one QCK edge in RUN; last config bit to CFG_DONE two edges.
// Backpressure: none; CFG_EN low simply pauses the load, shifts are accepted on any enabled cycle except APPLY.
//
// Ports:
//   QCK, QRT          clock and asynchronous active-high reset
//   CFG_EN, CFG_DI    config shift enable and serial data in
//   CFG_DO            serial data out (oldest bit of the chain) for daisy-chaining
//   CFG_DONE          high while the cluster is in RUN
//   FZ, QDI, QDS      per-slice data candidates and shared select (0 = FZ, 1 = QDI)
//   QEN, QST          per-slice enable and shared synchronous set
//   QZ                registered outputs after inversion
module q_frag_cluster
    import q_frag_pkg::*;
#(
    parameter int NUM_CELLS = 4
) (
    input  logic                 QCK,
    input  logic                 QRT,
    input  logic                 CFG_EN,
    input  logic                 CFG_DI,
    output logic                 CFG_DO,
    output logic                 CFG_DONE,
    input  logic [NUM_CELLS-1:0] FZ,
    input  logic [NUM_CELLS-1:0] QDI,
    input  logic                 QDS,
    input  logic [NUM_CELLS-1:0] QEN,
    input  logic                 QST,
    output logic [NUM_CELLS-1:0] QZ
);

    localparam int CFG_BITS = CFG_BITS_PER_CELL * NUM_CELLS;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [CFG_BITS-1:0]   sr, sr_nxt;
    logic [NUM_CELLS-1:0]  init_r, init_nxt;
    logic [NUM_CELLS-1:0]  zinv_r, zinv_nxt;
    logic                  shift;
    logic                  apply;
    logic                  run;

    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            state  <= IDLE;
            cnt    <= '0;
            sr     <= '0;
            init_r <= '0;
            zinv_r <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            sr     <= sr_nxt;
            init_r <= init_nxt;
            zinv_r <= zinv_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        init_nxt  = init_r;
        zinv_nxt  = zinv_r;
        shift     = 1'b0;
        apply     = 1'b0;

        case (state)
            IDLE: begin
                if (CFG_EN) begin
                    shift     = 1'b1;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (CFG_EN) begin
                    shift   = 1'b1;
                    cnt_nxt = cnt + CNT_W'(1);
                    // This shift completes the chain, so leave LOAD on the same edge.
                    if (cnt == CNT_W'(CFG_BITS - 1)) begin
                        state_nxt = APPLY;
                    end
                end
            end
            APPLY: begin
                // CFG_EN is deliberately not looked at here.
                apply     = 1'b1;
                init_nxt  = sr[NUM_CELLS-1:0];
                zinv_nxt  = sr[CFG_BITS-1:NUM_CELLS];
                state_nxt = RUN;
            end
            RUN: begin
                if (CFG_EN) begin
                    shift     = 1'b1;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // First bit in travels down to sr[0] once the chain is full.
        if (shift) begin
            sr_nxt = {CFG_DI, sr[CFG_BITS-1:1]};
        end
    end

    assign run      = (state == RUN);
    assign CFG_DONE = run;
    assign CFG_DO   = sr[0];

    // init_nxt carries the freshly captured INIT on the APPLY cycle, so the
    // slices load the same value that init_r registers.
    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_slice
        q_frag_slice u_slice (
            .clk       (QCK),
            .rst       (QRT),
            .run       (run),
            .load_init (apply),
            .init_bit  (init_nxt[i]),
            .qds       (QDS),
            .fz        (FZ[i]),
            .qdi       (QDI[i]),
            .qen       (QEN[i]),
            .qst       (QST),
            .zinv      (zinv_r[i]),
            .qz        (QZ[i])
        );
    end

endmodule

// File: tb/tb_q_frag_cluster.sv
module tb_q_frag_cluster;

    localparam int N = 4;

    logic         QCK = 1'b0;
    logic         QRT;
    logic         CFG_EN;
    logic         CFG_DI;
    logic         CFG_DO;
    logic         CFG_DONE;
    logic [N-1:0] FZ;
    logic [N-1:0] QDI;
    logic         QDS;
    logic [N-1:0] QEN;
    logic         QST;
    logic [N-1:0] QZ;

    q_frag_cluster #(.NUM_CELLS(N)) dut (
        .QCK      (QCK),
        .QRT      (QRT),
        .CFG_EN   (CFG_EN),
        .CFG_DI   (CFG_DI),
        .CFG_DO   (CFG_DO),
        .CFG_DONE (CFG_DONE),
        .FZ       (FZ),
        .QDI      (QDI),
        .QDS      (QDS),
        .QEN      (QEN),
        .QST      (QST),
        .QZ       (QZ)
    );

    always #5 QCK = ~QCK;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [N-1:0] qz;
        logic         done;
        logic         dout;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];

    // Reference model state.
    logic [2*N-1:0] m_sr;
    logic [N-1:0]   m_q;
    logic [N-1:0]   m_zinv;
    int             m_cnt;
    bit             m_run;
    bit             m_load;
    bit             m_apply;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_sr    = '0;
        m_q     = '0;
        m_zinv  = '0;
        m_cnt   = 0;
        m_run   = 0;
        m_load  = 0;
        m_apply = 0;
        sb.delete();
        sb_tag.delete();
    endtask

    // Drive one cycle, predict the post-edge outputs, then compare them.
    task automatic cyc(input string tag, input logic en, input logic di, input logic qds,
                       input logic [N-1:0] fz, input logic [N-1:0] qdi,
                       input logic [N-1:0] qen, input logic qst);
        exp_t         e;
        string        t;
        logic [N-1:0] d;
        CFG_EN = en; CFG_DI = di; QDS = qds; FZ = fz; QDI = qdi; QEN = qen; QST = qst;
        if (m_apply) begin
            m_q     = m_sr[N-1:0];
            m_zinv  = m_sr[2*N-1:N];
            m_apply = 0;
            m_run   = 1;
        end else begin
            if (m_run) begin
                d = qds ? qdi : fz;
                if (qst) m_q = '1;
                else     m_q = (m_q & ~qen) | (d & qen);
            end
            if (en) begin
                m_sr = {di, m_sr[2*N-1:1]};
                if (!m_load) begin
                    m_load = 1;
                    m_run  = 0;
                    m_cnt  = 1;
                end else begin
                    m_cnt++;
                end
                if (m_cnt == 2*N) begin
                    m_load  = 0;
                    m_apply = 1;
                end
            end
        end
        e.qz   = m_q ^ m_zinv;
        e.done = m_run;
        e.dout = m_sr[0];
        sb.push_back(e);
        sb_tag.push_back(tag);
        @(posedge QCK);
        #1;
        e = sb.pop_front();
        t = sb_tag.pop_front();
        chk_eq({t, ".qz"},   32'(QZ),       32'(e.qz));
        chk_eq({t, ".done"}, 32'(CFG_DONE), 32'(e.done));
        chk_eq({t, ".do"},   32'(CFG_DO),   32'(e.dout));
    endtask

    task automatic run_cyc(input string tag, input logic qds, input logic [N-1:0] fz,
                           input logic [N-1:0] qdi, input logic [N-1:0] qen, input logic qst);
        cyc(tag, 1'b0, 1'b0, qds, fz, qdi, qen, qst);
    endtask

    task automatic noise_cyc(input string tag);
        cyc(tag, 1'b0, 1'b0, 1'($urandom_range(0, 1)), N'($urandom_range(0, 15)),
            N'($urandom_range(0, 15)), N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    endtask

    // Full chain load; first bit fed ends at sr[0]. With gap set, idle cycles
    // (carrying random data-path stimulus) are inserted between shifts.
    task automatic load_cfg(input string tag, input logic [N-1:0] init, input logic [N-1:0] zinv,
                            input bit gap);
        logic [2*N-1:0] b;
        b = {zinv, init};
        for (int i = 0; i < 2*N; i++) begin
            cyc(tag, 1'b1, b[i], 1'b0, '0, '0, '0, 1'b0);
            if (gap && i < 2*N-1) begin
                for (int g = 0; g < (i % 3) + (i == 6 ? 5 : 0); g++) noise_cyc({tag, ".gap"});
            end
        end
        run_cyc({tag, ".apply"}, 1'b0, '0, '0, '0, 1'b0);
        run_cyc({tag, ".run"},   1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic async_rst(input string tag);
        CFG_EN = 0; QST = 0; QEN = '0;
        #3;
        QRT = 1'b1;
        #1;
        chk_eq({tag, ".qz"},   32'(QZ),       32'h0);
        chk_eq({tag, ".done"}, 32'(CFG_DONE), 32'h0);
        chk_eq({tag, ".do"},   32'(CFG_DO),   32'h0);
        @(posedge QCK);
        #1;
        QRT = 1'b0;
        m_reset();
    endtask

    initial begin
        QRT = 1'b1; CFG_EN = 0; CFG_DI = 0; FZ = '0; QDI = '0; QDS = 0; QEN = '0; QST = 0;
        m_reset();
        #2;
        chk_eq("rst.qz",   32'(QZ),       32'h0);
        chk_eq("rst.done", 32'(CFG_DONE), 32'h0);
        chk_eq("rst.do",   32'(CFG_DO),   32'h0);
        @(posedge QCK);
        #1;
        QRT = 1'b0;

        // Bits 1,0,1,1,0,0,1,0: INIT=1101, ZINV=0100.
        load_cfg("t2", 4'b1101, 4'b0100, 1'b0);
        chk_eq("t2.qz_lit",   32'(QZ),       32'b1001);
        chk_eq("t2.done_lit", 32'(CFG_DONE), 32'h1);

        run_cyc("t4a", 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        chk_eq("t4a.qz_lit", 32'(QZ), 32'b1011);

        // Reload from RUN: three shifts, then set/enable traffic must be ignored.
        cyc("rl", 1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0);
        chk_eq("rl.done_lit", 32'(CFG_DONE), 32'h0);
        cyc("rl", 1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0);
        cyc("rl", 1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0);
        run_cyc("rl.ign", 1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b1);
        chk_eq("rl.qz_hold", 32'(QZ),     32'b1011);
        chk_eq("rl.do_lit",  32'(CFG_DO), 32'h1);
        async_rst("t1");

        // Gapped loads; the second one shifts the first image out on CFG_DO.
        load_cfg("t5a", 4'b0110, 4'b1001, 1'b1);
        chk_eq("t5a.qz_lit", 32'(QZ), 32'b1111);
        load_cfg("t5b", 4'b0000, 4'b0000, 1'b1);
        chk_eq("t5b.qz_lit", 32'(QZ), 32'b0000);

        run_cyc("t3a", 1'b0, 4'b1010, 4'b0000, 4'b1111, 1'b0);
        chk_eq("t3a.qz_lit", 32'(QZ), 32'b1010);
        run_cyc("t3b", 1'b1, 4'b0000, 4'b0110, 4'b0011, 1'b0);
        chk_eq("t3b.qz_lit", 32'(QZ), 32'b1010);
        run_cyc("t4b", 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        chk_eq("t4b.qz_lit", 32'(QZ), 32'b1111);
        run_cyc("t4c", 1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b1);
        chk_eq("t4c.qz_lit", 32'(QZ), 32'b1111);
        run_cyc("hold", 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        for (int k = 0; k < 40; k++) noise_cyc("rand");

        // Reload from RUN with data-path noise in the gaps.
        load_cfg("t6", 4'b0011, 4'b1111, 1'b1);
        chk_eq("t6.qz_lit", 32'(QZ), 32'b1100);
        for (int k = 0; k < 20; k++) noise_cyc("rand2");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
